// File: rtl/event_frame_builder_pkg.sv
// Shared definitions for the event frame builder: FSM encodings, default
// header/trailer tags and frame word layout helpers.
package event_frame_builder_pkg;

  localparam logic [7:0] C_HEADER_TAG  = 8'hA5;
  localparam logic [7:0] C_TRAILER_TAG = 8'h5A;

  // Header carries the length in its low 16 bits, trailer the trigger count in its low 12.
  localparam int C_HDR_LEN_W = 16;
  localparam int C_TRG_W     = 12;

  typedef logic [2:0] t_state;

  localparam t_state ST_IDLE    = 3'd0;
  localparam t_state ST_HEADER  = 3'd1;
  localparam t_state ST_EVNUM   = 3'd2;
  localparam t_state ST_DATA    = 3'd3;
  localparam t_state ST_TRAILER = 3'd4;

  function automatic logic [31:0] f_header(input logic [7:0] tag,
                                           input logic [C_HDR_LEN_W-1:0] len);
    return {tag, 8'h00, len};
  endfunction

  function automatic logic [31:0] f_trailer(input logic [7:0] tag,
                                            input logic [C_TRG_W-1:0] trg);
    return {tag, 12'h000, trg};
  endfunction

endpackage

// File: rtl/event_frame_builder_payload_buffer.sv
// Payload side of the frame builder: issues lockstep FIFO reads, holds one
// 64-bit sample set and hands it out as two 32-bit words, counting triggers.
module frame_payload_buffer
  import event_frame_builder_pkg::*;
#(
  parameter int g_Len_Width = 12
) (
  input  logic                   Clock,
  input  logic                   Reset_N,
  input  logic                   i_load,
  input  logic [g_Len_Width-1:0] i_len,
  input  logic                   i_active,
  input  logic                   i_clear_trg,
  input  logic                   i_fifo_empty,
  input  logic                   i_out_ready,
  input  logic [15:0]            i_q0,
  input  logic [15:0]            i_q1,
  input  logic [15:0]            i_q2,
  input  logic [15:0]            i_q3,
  output logic                   o_re,
  output logic                   o_word_valid,
  output logic [31:0]            o_word,
  output logic                   o_done,
  output logic [C_TRG_W-1:0]     o_trg_cnt
);

  logic [63:0]            r_h;
  logic                   r_h_valid;
  logic                   r_half;
  logic                   r_rd_pending;
  logic [g_Len_Width-1:0] r_rd_remaining;
  logic [C_TRG_W-1:0]     r_trg_cnt;

  logic w_word_accept;
  logic w_slot_free;
  logic w_any_trg;

  assign w_word_accept = i_active & r_h_valid & i_out_ready;
  // A new read may be issued while the second half is leaving, so the
  // refill overlaps the last handshake of the previous sample set.
  assign w_slot_free   = ~r_h_valid | (r_half & i_out_ready);
  assign w_any_trg     = i_q0[15] | i_q1[15] | i_q2[15] | i_q3[15];

  assign o_re = i_active & (r_rd_remaining != '0) & ~i_fifo_empty
              & ~r_rd_pending & w_slot_free;
  assign o_done = w_word_accept & r_half & (r_rd_remaining == '0) & ~r_rd_pending;

  assign o_word_valid = r_h_valid;
  assign o_word       = r_half ? r_h[63:32] : r_h[31:0];
  assign o_trg_cnt    = r_trg_cnt;

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_h            <= '0;
      r_h_valid      <= 1'b0;
      r_half         <= 1'b0;
      r_rd_pending   <= 1'b0;
      r_rd_remaining <= '0;
      r_trg_cnt      <= '0;
    end else begin
      if (i_load) begin
        r_rd_remaining <= i_len;
      end else if (o_re) begin
        r_rd_remaining <= r_rd_remaining - 1'b1;
      end

      r_rd_pending <= o_re;

      if (r_rd_pending) begin
        r_h       <= {i_q3, i_q2, i_q1, i_q0};
        r_h_valid <= 1'b1;
        r_half    <= 1'b0;
      end else if (w_word_accept) begin
        if (r_half) begin
          r_h_valid <= 1'b0;
          r_half    <= 1'b0;
        end else begin
          r_half <= 1'b1;
        end
      end

      if (i_clear_trg) begin
        r_trg_cnt <= '0;
      end else if (r_rd_pending && w_any_trg && (r_trg_cnt != '1)) begin
        r_trg_cnt <= r_trg_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_frame_builder.sv
// Packs one event from the four channel FIFOs into a 32-bit framed stream
// (header, event number, payload, trailer) with a valid/ready output.
module event_frame_builder
  import event_frame_builder_pkg::*;
#(
  parameter int         g_Len_Width   = 12,
  parameter logic [7:0] g_Header_Tag  = C_HEADER_TAG,
  parameter logic [7:0] g_Trailer_Tag = C_TRAILER_TAG
) (
  input  logic                   Clock,
  input  logic                   Reset_N,
  input  logic                   Event_Start,
  input  logic [g_Len_Width-1:0] Sample_Words,
  input  logic                   Fifo_Empty,
  output logic                   RE,
  input  logic [15:0]            Q_0,
  input  logic [15:0]            Q_1,
  input  logic [15:0]            Q_2,
  input  logic [15:0]            Q_3,
  output logic [31:0]            Out_Data,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic                   Out_Last,
  output logic                   Busy,
  output logic [15:0]            Dropped_Count
);

  t_state                 r_state;
  logic [g_Len_Width-1:0] r_len;
  logic [31:0]            r_event_cnt;
  logic [15:0]            r_dropped;

  logic                   w_hs;
  logic                   w_busy;
  logic                   w_pl_valid;
  logic [31:0]            w_pl_word;
  logic                   w_pl_done;
  logic [C_TRG_W-1:0]     w_trg_cnt;

  assign w_busy        = (r_state != ST_IDLE);
  assign w_hs          = Out_Valid & Out_Ready;
  assign Busy          = w_busy;
  assign Dropped_Count = r_dropped;

  frame_payload_buffer #(
    .g_Len_Width (g_Len_Width)
  ) u_payload (
    .Clock        (Clock),
    .Reset_N      (Reset_N),
    .i_load       ((r_state == ST_EVNUM) && w_hs),
    .i_len        (r_len),
    .i_active     (r_state == ST_DATA),
    .i_clear_trg  ((r_state == ST_TRAILER) && w_hs),
    .i_fifo_empty (Fifo_Empty),
    .i_out_ready  (Out_Ready),
    .i_q0         (Q_0),
    .i_q1         (Q_1),
    .i_q2         (Q_2),
    .i_q3         (Q_3),
    .o_re         (RE),
    .o_word_valid (w_pl_valid),
    .o_word       (w_pl_word),
    .o_done       (w_pl_done),
    .o_trg_cnt    (w_trg_cnt)
  );

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_event_cnt <= '0;
      r_dropped   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Event_Start) begin
            r_len   <= Sample_Words;
            r_state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (w_hs) r_state <= ST_EVNUM;
        end
        ST_EVNUM: begin
          if (w_hs) begin
            r_event_cnt <= r_event_cnt + 32'd1;
            r_state     <= (r_len != '0) ? ST_DATA : ST_TRAILER;
          end
        end
        ST_DATA: begin
          if (w_pl_done) r_state <= ST_TRAILER;
        end
        ST_TRAILER: begin
          if (w_hs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Includes the trailer handshake cycle, where Busy is still high.
      if (Event_Start && w_busy && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  always_comb begin
    Out_Data  = '0;
    Out_Valid = 1'b0;
    Out_Last  = 1'b0;
    case (r_state)
      ST_HEADER: begin
        Out_Data  = f_header(g_Header_Tag, C_HDR_LEN_W'(r_len));
        Out_Valid = 1'b1;
      end
      ST_EVNUM: begin
        Out_Data  = r_event_cnt;
        Out_Valid = 1'b1;
      end
      ST_DATA: begin
        Out_Data  = w_pl_word;
        Out_Valid = w_pl_valid;
      end
      ST_TRAILER: begin
        Out_Data  = f_trailer(g_Trailer_Tag, w_trg_cnt);
        Out_Valid = 1'b1;
        Out_Last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_event_frame_builder.sv
// Directed bench for event_frame_builder: FIFO model, output collector and
// frame checks for nominal, empty, back-pressured, stalled and aborted events.
module tb_event_frame_builder;

  logic        Clock = 1'b0;
  logic        Reset_N = 1'b0;
  logic        Event_Start = 1'b0;
  logic [11:0] Sample_Words = '0;
  logic        Fifo_Empty;
  logic        RE;
  logic [15:0] Q_0, Q_1, Q_2, Q_3;
  logic [31:0] Out_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Out_Last;
  logic        Busy;
  logic [15:0] Dropped_Count;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  event_frame_builder dut (
    .Clock         (Clock),
    .Reset_N       (Reset_N),
    .Event_Start   (Event_Start),
    .Sample_Words  (Sample_Words),
    .Fifo_Empty    (Fifo_Empty),
    .RE            (RE),
    .Q_0           (Q_0),
    .Q_1           (Q_1),
    .Q_2           (Q_2),
    .Q_3           (Q_3),
    .Out_Data      (Out_Data),
    .Out_Valid     (Out_Valid),
    .Out_Ready     (Out_Ready),
    .Out_Last      (Out_Last),
    .Busy          (Busy),
    .Dropped_Count (Dropped_Count)
  );

  // Channel FIFO model: one-cycle read latency, shared pointer.
  logic [15:0] qmem [0:3][0:63];
  int   wr_cnt = 0;
  int   rd_ptr;
  logic force_empty = 1'b0;
  logic flush_req = 1'b0;

  assign Fifo_Empty = force_empty | (rd_ptr >= wr_cnt);

  always_ff @(posedge Clock) begin
    if (flush_req) begin
      rd_ptr <= wr_cnt;
    end else if (RE) begin
      Q_0    <= qmem[0][rd_ptr];
      Q_1    <= qmem[1][rd_ptr];
      Q_2    <= qmem[2][rd_ptr];
      Q_3    <= qmem[3][rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  bit rand_mode = 1'b0;
  initial begin
    Out_Ready = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      Out_Ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output collector and stall-stability monitor, sampled mid-cycle.
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          re_cnt = 0;
  int          gap_re = 0;
  int          stall_err = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;

  initial forever begin
    @(negedge Clock);
    if (RE === 1'b1) begin
      re_cnt++;
      if (force_empty) gap_re++;
    end
    if (stall_prev && Reset_N &&
        (Out_Valid !== 1'b1 || Out_Data !== stall_data || Out_Last !== stall_last))
      stall_err++;
    if (Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
      got_d.push_back(Out_Data);
      got_l.push_back(Out_Last);
    end
    stall_prev = (Out_Valid === 1'b1) && (Out_Ready === 1'b0) && Reset_N;
    stall_data = Out_Data;
    stall_last = Out_Last;
  end

  logic [31:0] exp_d[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit trg0, input bit trg3);
    for (int i = 0; i < 4; i++) begin
      qmem[i][wr_cnt] = {1'b0, 3'b000, 12'(wr_cnt * 4 + i + 1)};
    end
    qmem[0][wr_cnt][15] = trg0;
    qmem[3][wr_cnt][15] = trg3;
    wr_cnt++;
  endtask

  task automatic build_frame(input int ev, input int len, input int base, input int trg);
    exp_d.delete();
    exp_d.push_back({8'hA5, 8'h00, 4'h0, 12'(len)});
    exp_d.push_back(32'(ev));
    for (int p = base; p < base + len; p++) begin
      exp_d.push_back({qmem[1][p], qmem[0][p]});
      exp_d.push_back({qmem[3][p], qmem[2][p]});
    end
    exp_d.push_back({8'h5A, 12'h000, 12'(trg)});
  endtask

  task automatic check_frame(input string tag, input int qbase);
    int n;
    n = got_d.size() - qbase;
    chk({tag, "_nwords"}, 32'(n), 32'(exp_d.size()));
    for (int j = 0; j < exp_d.size(); j++) begin
      if (j < n) begin
        chk($sformatf("%s_w%0d", tag, j), got_d[qbase + j], exp_d[j]);
        chk($sformatf("%s_last%0d", tag, j), 32'(got_l[qbase + j]),
            32'(j == exp_d.size() - 1));
      end
    end
  endtask

  task automatic start_event(input int len);
    @(posedge Clock);
    #1;
    Sample_Words = 12'(len);
    Event_Start  = 1'b1;
    @(posedge Clock);
    #1;
    Event_Start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy !== 1'b0 && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(Busy), 32'd0);
  endtask

  task automatic wait_re(input string tag, input int base, input int target);
    int n = 0;
    while ((re_cnt - base) < target && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk({tag, "_re_timeout"}, 32'(re_cnt - base), 32'(target));
  endtask

  logic [31:0] exp1 [0:6];
  int qb, rb, gb, sb, base;

  initial begin
    exp1[0] = 32'hA500_0002; exp1[1] = 32'h0000_0000;
    exp1[2] = 32'h0002_0001; exp1[3] = 32'h0004_0003;
    exp1[4] = 32'h0006_0005; exp1[5] = 32'h0008_0007;
    exp1[6] = 32'h5A00_0000;

    // Reset state
    #2;
    chk("rst_re", 32'(RE), 0);
    chk("rst_valid", 32'(Out_Valid), 0);
    chk("rst_last", 32'(Out_Last), 0);
    chk("rst_data", Out_Data, 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_dropped", 32'(Dropped_Count), 0);
    repeat (2) @(posedge Clock);
    #1;
    Reset_N = 1'b1;

    // Event 0: two reads, ramp data, Out_Ready held high
    push(1'b0, 1'b0); push(1'b0, 1'b0);
    qb = got_d.size(); rb = re_cnt;
    start_event(2);
    chk("t1_hdr_valid", 32'(Out_Valid), 1);
    chk("t1_hdr_data", Out_Data, 32'hA500_0002);
    chk("t1_busy", 32'(Busy), 1);
    wait_idle("t1");
    chk("t1_nwords", 32'(got_d.size() - qb), 7);
    for (int j = 0; j < 7; j++) begin
      if (qb + j < got_d.size()) begin
        chk($sformatf("t1_w%0d", j), got_d[qb + j], exp1[j]);
        chk($sformatf("t1_last%0d", j), 32'(got_l[qb + j]), 32'(j == 6));
      end
    end
    chk("t1_re_pulses", 32'(re_cnt - rb), 2);
    chk("t1_idle_valid", 32'(Out_Valid), 0);

    // Event 1: zero-length payload
    qb = got_d.size(); rb = re_cnt;
    start_event(0);
    wait_idle("t2");
    build_frame(1, 0, 0, 0);
    check_frame("t2", qb);
    chk("t2_re_pulses", 32'(re_cnt - rb), 0);

    // Event 2: sixteen reads under random back-pressure
    base = wr_cnt;
    for (int k = 0; k < 16; k++) push(1'b0, 1'b0);
    qb = got_d.size(); rb = re_cnt; sb = stall_err;
    rand_mode = 1'b1;
    start_event(16);
    wait_idle("t3");
    rand_mode = 1'b0;
    build_frame(2, 16, base, 0);
    check_frame("t3", qb);
    chk("t3_re_pulses", 32'(re_cnt - rb), 16);
    chk("t3_stall_stable", 32'(stall_err - sb), 0);

    // Event 3: FIFO empty gap mid-payload, triggers on reads 1 and 3
    base = wr_cnt;
    push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b1); push(1'b0, 1'b0);
    qb = got_d.size(); rb = re_cnt;
    start_event(4);
    wait_re("t4", rb, 2);
    @(posedge Clock);
    #1;
    force_empty = 1'b1;
    gb = gap_re;
    repeat (10) @(posedge Clock);
    #1;
    chk("t4_gap_re", 32'(gap_re - gb), 0);
    chk("t4_gap_re_total", 32'(re_cnt - rb), 2);
    chk("t4_gap_valid", 32'(Out_Valid), 0);
    chk("t4_gap_busy", 32'(Busy), 1);
    force_empty = 1'b0;
    wait_idle("t4");
    build_frame(3, 4, base, 2);
    check_frame("t4", qb);

    // Event 4: three starts ignored while busy
    base = wr_cnt;
    push(1'b0, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
    qb = got_d.size();
    start_event(3);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clock); #1; Event_Start = 1'b1;
      @(posedge Clock); #1; Event_Start = 1'b0;
    end
    wait_idle("t5");
    chk("t5_dropped", 32'(Dropped_Count), 3);
    build_frame(4, 3, base, 0);
    check_frame("t5", qb);

    // Event 5: next event number follows on
    base = wr_cnt;
    push(1'b0, 1'b0);
    qb = got_d.size();
    start_event(1);
    wait_idle("t6");
    build_frame(5, 1, base, 0);
    check_frame("t6", qb);

    // Reset asserted mid-payload, then a clean event
    push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
    rb = re_cnt;
    start_event(4);
    wait_re("t7", rb, 2);
    @(posedge Clock);
    #3;
    Reset_N = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(Out_Valid), 0);
    chk("t7_rst_data", Out_Data, 0);
    chk("t7_rst_last", 32'(Out_Last), 0);
    chk("t7_rst_busy", 32'(Busy), 0);
    chk("t7_rst_re", 32'(RE), 0);
    chk("t7_rst_dropped", 32'(Dropped_Count), 0);
    flush_req = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    flush_req = 1'b0;
    Reset_N = 1'b1;
    base = wr_cnt;
    push(1'b0, 1'b0);
    qb = got_d.size();
    start_event(1);
    wait_idle("t7");
    build_frame(0, 1, base, 0);
    check_frame("t7", qb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
